// File: rtl/button_debounce_channel.sv
`default_nettype none
// ============================================================================
// Module      : button_debounce_channel
// Description : One button channel. The raw input is optionally inverted,
//               then passed through a synchroniser chain and a counter-based
//               stability filter. The channel produces a registered level,
//               press and release pulses, and an optional long-press pulse.
// Ports       : clk            - system clock, rising edge
//               rst            - synchronous reset, active-low
//               raw            - raw asynchronous button input
//               level          - debounced pressed state (1 = pressed)
//               press_pulse    - 1-cycle pulse when level goes 0->1
//               release_pulse  - 1-cycle pulse when level goes 1->0
//               long_pulse     - 1-cycle pulse once LONG_CYCLES into a hold
//               level_next     - combinational next value of level
// Revision    : 1.0 - initial release
// ============================================================================
module button_debounce_channel #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16,
  parameter int LONG_CYCLES   = 0,
  parameter int ACTIVE_LOW    = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic level_next
);

  localparam int               CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  // Invert ahead of the synchroniser. As a result, the reset value of the
  // chain (all zeros) always means "not pressed", so releasing reset cannot
  // generate a spurious pulse.
  logic pressed_raw;
  assign pressed_raw = (ACTIVE_LOW != 0) ? ~raw : raw;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sample;
  assign sample = sync_q[SYNC_STAGES-1];

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_next;
  logic             flip;

  // Count consecutive samples that disagree with the current level. If a
  // sample agrees with the level, the run is broken and the count returns
  // to zero. The level flips on the sample that completes the run.
  always_comb begin
    cnt_next = '0;
    flip     = 1'b0;
    if (sample != level) begin
      if (cnt_q == CNT_LAST) begin
        flip = 1'b1;
      end else begin
        cnt_next = cnt_q + CNT_W'(1);
      end
    end
  end

  assign level_next = flip ? sample : level;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q        <= '0;
      cnt_q         <= '0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync_q        <= {sync_q[SYNC_STAGES-2:0], pressed_raw};
      cnt_q         <= cnt_next;
      level         <= level_next;
      press_pulse   <= flip & sample;
      release_pulse <= flip & ~sample;
    end
  end

  generate
    if (LONG_CYCLES > 0) begin : g_long
      localparam int            HW       = $clog2(LONG_CYCLES + 1);
      localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);

      logic [HW-1:0] hold_q;
      logic [HW-1:0] hold_next;

      // Hold counter follows the next level. As a result, the cycle that
      // carries the press pulse already registers a hold count of 1.
      always_comb begin
        hold_next = '0;
        if (level_next) begin
          hold_next = (hold_q == HOLD_MAX) ? HOLD_MAX : hold_q + HW'(1);
        end
      end

      // Saturation at HOLD_MAX ensures one pulse per hold.
      always_ff @(posedge clk) begin
        if (!rst) begin
          hold_q     <= '0;
          long_pulse <= 1'b0;
        end else begin
          hold_q     <= hold_next;
          long_pulse <= (hold_q != HOLD_MAX) && (hold_next == HOLD_MAX);
        end
      end
    end else begin : g_no_long
      assign long_pulse = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/multi_button_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : multi_button_debouncer
// Description : Array of N_BUTTONS independent button debouncers. The module
//               also provides a registered "any button pressed" flag.
// Ports       : clk              - system clock, rising edge
//               rst              - synchronous reset, active-low
//               b_in             - raw asynchronous button inputs
//               b_level          - debounced pressed state (1 = pressed)
//               b_press_pulse    - 1-cycle pulse on level 0->1
//               b_release_pulse  - 1-cycle pulse on level 1->0
//               b_long_pulse     - 1-cycle pulse, LONG_CYCLES into a hold
//               b_any            - OR of b_level, aligned with the levels
// Revision    : 1.0 - initial release
// ============================================================================
module multi_button_debouncer #(
  parameter int N_BUTTONS     = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16,
  parameter int LONG_CYCLES   = 0,
  parameter int ACTIVE_LOW    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_BUTTONS-1:0] b_in,
  output logic [N_BUTTONS-1:0] b_level,
  output logic [N_BUTTONS-1:0] b_press_pulse,
  output logic [N_BUTTONS-1:0] b_release_pulse,
  output logic [N_BUTTONS-1:0] b_long_pulse,
  output logic                 b_any
);

  logic [N_BUTTONS-1:0] level_next;

  generate
    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
      button_debounce_channel #(
        .SYNC_STAGES  (SYNC_STAGES),
        .STABLE_CYCLES(STABLE_CYCLES),
        .LONG_CYCLES  (LONG_CYCLES),
        .ACTIVE_LOW   (ACTIVE_LOW)
      ) u_ch (
        .clk          (clk),
        .rst          (rst),
        .raw          (b_in[i]),
        .level        (b_level[i]),
        .press_pulse  (b_press_pulse[i]),
        .release_pulse(b_release_pulse[i]),
        .long_pulse   (b_long_pulse[i]),
        .level_next   (level_next[i])
      );
    end
  endgenerate

  // b_any is built from the next levels. If it were built from the
  // registered levels, it would lag b_level by one cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      b_any <= 1'b0;
    end else begin
      b_any <= |level_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_button_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_button_debouncer
// Description : Self-checking bench for multi_button_debouncer. Two instances
//               are exercised: one active-high and one active-low. A
//               cycle-level reference model queues the expected outputs on
//               every clock. Those expectations are compared against the DUT
//               shortly after the edge. Directed checks cover the headline
//               timing cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_button_debouncer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] b0  = 4'h0;
  logic [3:0] b1  = 4'hF;

  logic [3:0] b_level0, b_press0, b_release0, b_long0;
  logic [3:0] b_level1, b_press1, b_release1, b_long1;
  logic       b_any0, b_any1;

  always #5 clk = ~clk;

  multi_button_debouncer #(
    .N_BUTTONS(4), .SYNC_STAGES(2), .STABLE_CYCLES(4), .LONG_CYCLES(10), .ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .rst(rst), .b_in(b0), .b_level(b_level0), .b_press_pulse(b_press0),
    .b_release_pulse(b_release0), .b_long_pulse(b_long0), .b_any(b_any0)
  );

  multi_button_debouncer #(
    .N_BUTTONS(4), .SYNC_STAGES(2), .STABLE_CYCLES(4), .LONG_CYCLES(10), .ACTIVE_LOW(1)
  ) dut_al (
    .clk(clk), .rst(rst), .b_in(b1), .b_level(b_level1), .b_press_pulse(b_press1),
    .b_release_pulse(b_release1), .b_long_pulse(b_long1), .b_any(b_any1)
  );

  typedef struct packed {
    logic [3:0] lvl;
    logic [3:0] pr;
    logic [3:0] rl;
    logic [3:0] lg;
    logic       any;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int compared   = 0;
  int mismatched = 0;

  // Reference model state: [instance][channel]
  logic m_syn1[2][4];
  logic m_syn2[2][4];
  logic m_lvl [2][4];
  int   m_cnt [2][4];
  int   m_hold[2][4];

  // Pulse tallies for the active-high instance, gathered by run()
  int prc[4];
  int rlc[4];
  int lgc[4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at each rising edge with the inputs the DUT samples there.
  task automatic model_tick();
    for (int k = 0; k < 2; k++) begin
      exp_t       e;
      logic [3:0] lin;
      e   = '0;
      lin = (k == 0) ? b0 : ~b1;
      for (int c = 0; c < 4; c++) begin
        if (!rst) begin
          m_syn1[k][c] = 1'b0;
          m_syn2[k][c] = 1'b0;
          m_lvl[k][c]  = 1'b0;
          m_cnt[k][c]  = 0;
          m_hold[k][c] = 0;
        end else begin
          logic s;
          s            = m_syn2[k][c];
          m_syn2[k][c] = m_syn1[k][c];
          m_syn1[k][c] = lin[c];
          if (s != m_lvl[k][c]) begin
            m_cnt[k][c]++;
            if (m_cnt[k][c] == 4) begin
              m_lvl[k][c] = s;
              m_cnt[k][c] = 0;
              if (s) e.pr[c] = 1'b1;
              else   e.rl[c] = 1'b1;
            end
          end else begin
            m_cnt[k][c] = 0;
          end
          if (m_lvl[k][c]) begin
            if (m_hold[k][c] < 10) begin
              m_hold[k][c]++;
              if (m_hold[k][c] == 10) e.lg[c] = 1'b1;
            end
          end else begin
            m_hold[k][c] = 0;
          end
        end
        e.lvl[c] = m_lvl[k][c];
      end
      e.any = |e.lvl;
      if (k == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  task automatic compare_outputs();
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("sb0_level",   32'(b_level0),   32'(e.lvl));
      chk("sb0_press",   32'(b_press0),   32'(e.pr));
      chk("sb0_release", 32'(b_release0), 32'(e.rl));
      chk("sb0_long",    32'(b_long0),    32'(e.lg));
      chk("sb0_any",     32'(b_any0),     32'(e.any));
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("sb1_level",   32'(b_level1),   32'(e.lvl));
      chk("sb1_press",   32'(b_press1),   32'(e.pr));
      chk("sb1_release", 32'(b_release1), 32'(e.rl));
      chk("sb1_long",    32'(b_long1),    32'(e.lg));
      chk("sb1_any",     32'(b_any1),     32'(e.any));
    end
  endtask

  // One clock: the model observes the edge, and the outputs are checked
  // 1 ns later. Stimulus changes only after this point.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      model_tick();
      #1;
      compare_outputs();
    end
  endtask

  task automatic clear_counts();
    for (int c = 0; c < 4; c++) begin
      prc[c] = 0;
      rlc[c] = 0;
      lgc[c] = 0;
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      step(1);
      for (int c = 0; c < 4; c++) begin
        prc[c] += int'(b_press0[c]);
        rlc[c] += int'(b_release0[c]);
        lgc[c] += int'(b_long0[c]);
      end
    end
  endtask

  initial begin
    // Reset
    step(3);
    chk("rst_level", 32'(b_level0), 32'h0);
    chk("rst_any",   32'(b_any0),   32'h0);
    rst = 1'b1;
    step(10);
    chk("al_idle_level", 32'(b_level1), 32'h0);

    // 1: clean press on channel 0
    b0[0] = 1'b1;
    step(5);
    chk("t1_early_press", 32'(b_press0), 32'h0);
    step(1);
    chk("t1_level", 32'(b_level0), 32'h1);
    chk("t1_press", 32'(b_press0), 32'h1);
    chk("t1_any",   32'(b_any0),   32'h1);
    step(1);
    chk("t1_press_once", 32'(b_press0), 32'h0);
    b0[0] = 1'b0;
    step(10);
    chk("t1_released", 32'(b_level0), 32'h0);

    // 2: bounce on channel 1, then a lone 3-cycle glitch
    clear_counts();
    b0[1] = 1'b1; run(2);
    b0[1] = 1'b0; run(2);
    b0[1] = 1'b1; run(2);
    b0[1] = 1'b0; run(2);
    b0[1] = 1'b1; run(5);
    chk("t2_no_early_press", 32'(prc[1]), 32'd0);
    run(1);
    chk("t2_press_at_6",  32'(b_press0[1]), 32'h1);
    chk("t2_single_press", 32'(prc[1]),     32'd1);
    b0[1] = 1'b0;
    run(12);
    clear_counts();
    b0[1] = 1'b1; run(3);
    b0[1] = 1'b0; run(10);
    chk("t2_glitch_press", 32'(prc[1]),      32'd0);
    chk("t2_glitch_level", 32'(b_level0[1]), 32'h0);

    // 3: long press on channel 2, then a short hold
    clear_counts();
    b0[2] = 1'b1;
    run(14);
    chk("t3_no_early_long", 32'(lgc[2]), 32'd0);
    run(1);
    chk("t3_long_at_10th", 32'(b_long0[2]), 32'h1);
    run(5);
    chk("t3_one_long", 32'(lgc[2]), 32'd1);
    clear_counts();
    b0[2] = 1'b0;
    run(10);
    chk("t3_release", 32'(rlc[2]), 32'd1);
    chk("t3_no_2nd_long", 32'(lgc[2]), 32'd0);
    clear_counts();
    b0[2] = 1'b1; run(5);
    b0[2] = 1'b0; run(12);
    chk("t3_short_press", 32'(prc[2]), 32'd1);
    chk("t3_short_long",  32'(lgc[2]), 32'd0);

    // 4: simultaneous presses on channels 0 and 3
    b0 = 4'b1001;
    step(6);
    chk("t4_press_pair", 32'(b_press0), 32'h9);
    b0 = 4'b1000;
    step(6);
    chk("t4_release_ch0", 32'(b_release0), 32'h1);
    chk("t4_level",       32'(b_level0),   32'h8);
    chk("t4_any_held",    32'(b_any0),     32'h1);
    b0 = 4'b0000;
    step(10);

    // 5: reset while all channels are pressed
    b0 = 4'hF;
    step(8);
    chk("t5_all_level", 32'(b_level0), 32'hF);
    rst = 1'b0;
    step(1);
    chk("t5_rst_level",   32'(b_level0),   32'h0);
    chk("t5_rst_release", 32'(b_release0), 32'h0);
    chk("t5_rst_any",     32'(b_any0),     32'h0);
    rst = 1'b1;
    clear_counts();
    run(5);
    chk("t5_no_early_press", 32'(prc[0] + prc[1] + prc[2] + prc[3]), 32'd0);
    run(1);
    chk("t5_repress", 32'(b_press0), 32'hF);
    b0 = 4'h0;
    step(10);

    // 6: active-low instance, channel 0 pressed by driving 0
    chk("t6_idle_level", 32'(b_level1), 32'h0);
    b1[0] = 1'b0;
    step(5);
    chk("t6_early_press", 32'(b_press1), 32'h0);
    step(1);
    chk("t6_press", 32'(b_press1), 32'h1);
    chk("t6_level", 32'(b_level1), 32'h1);
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
